uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with an integrated transmit FIFO. It generalises the single-byte transmitter: configurable data width, parity mode (none/even/odd), 1 or 2 stop bits and a buffered write interface. Writers push words at clk rate. The block serialises queued words back-to-back, with no idle gap, onto uart_tx. It sits between on-chip producers and the board UART pin.

---
 rtl/uart_tx_fifo.sv | 184 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated transmit FIFO. Queued words go out back-to-back:
// start bit, LSB-first data, optional parity, then 1 or 2 stop bits.
module uart_tx_fifo #(
  parameter int unsigned CLK_FREQ    = 100_000_000,
  parameter int unsigned BAUD_RATE   = 115200,
  parameter int          NCO_WIDTH   = 16,
  parameter int          DATA_BITS   = 8,
  parameter int          PARITY_MODE = 1,
  parameter int          STOP_BITS   = 1,
  parameter int          FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          dvld,
  input  logic [DATA_BITS-1:0]          data,
  output logic                          ready,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          busy,
  output logic                          uart_tx
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  // Rounded phase increment: one carry-out of the accumulator per bit period on average.
  localparam longint INC_WIDE =
    ((longint'(BAUD_RATE) << NCO_WIDTH) + longint'(CLK_FREQ / 2)) / longint'(CLK_FREQ);
  localparam logic [NCO_WIDTH-1:0] INC = INC_WIDE[NCO_WIDTH-1:0];

  localparam logic PAR_ODD = (PARITY_MODE == 2);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [2:0] ST_AFTER_DATA = (PARITY_MODE != 0) ? ST_PARITY : ST_STOP;

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if (INC_WIDE < 1 || INC_WIDE >= (longint'(1) << NCO_WIDTH)) begin : g_bad_inc
    $error("uart_tx_fifo: BAUD_RATE/CLK_FREQ not representable with NCO_WIDTH");
  end

  logic [2:0]             state;
  logic [NCO_WIDTH-1:0]   acc;
  logic [NCO_WIDTH:0]     acc_sum;
  logic                   tick;

  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [DATA_BITS-1:0]   head;

  logic [DATA_BITS-1:0]   shreg;
  logic                   par_bit;
  logic [3:0]             bit_cnt;
  logic                   stop_cnt;

  logic full, empty, push, pop, last_stop, frame_done;

  assign acc_sum    = {1'b0, acc} + {1'b0, INC};
  assign tick       = acc_sum[NCO_WIDTH];

  assign full       = (level == LW'(FIFO_DEPTH));
  assign empty      = (level == '0);
  assign ready      = ~full;
  assign push       = dvld & ~full;
  assign head       = mem[rd_ptr];

  assign last_stop  = (stop_cnt == 1'(STOP_BITS - 1));
  assign frame_done = (state == ST_STOP) && tick && last_stop;
  assign pop        = ~empty && ((state == ST_IDLE) || frame_done);
  assign busy       = (state != ST_IDLE) || ~empty;

  // NOTE: the storage array is deliberately not reset; pointers and level alone define
  // which entries are valid, so the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data;
  end

  // NOTE: every register uses <= so all of them sample pre-edge values, independent of
  // statement order within or across blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= dvld & full;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      acc      <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      uart_tx  <= 1'b1;
    end else begin
      // Line is a registered copy of the current state's bit: one clk behind, glitch-free.
      case (state)
        ST_START:  uart_tx <= 1'b0;
        ST_DATA:   uart_tx <= shreg[0];
        ST_PARITY: uart_tx <= par_bit;
        default:   uart_tx <= 1'b1;
      endcase

      // Phase restarts only on a frame leaving IDLE; back-to-back frames keep the phase.
      acc <= (state == ST_IDLE && !empty) ? '0 : acc_sum[NCO_WIDTH-1:0];

      case (state)
        ST_IDLE: begin
          if (!empty) begin
            shreg   <= head;
            par_bit <= (^head) ^ PAR_ODD;
            state   <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            bit_cnt <= '0;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            shreg <= shreg >> 1;
            if (bit_cnt == 4'(DATA_BITS - 1)) begin
              stop_cnt <= 1'b0;
              state    <= ST_AFTER_DATA;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            stop_cnt <= 1'b0;
            state    <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (!last_stop) begin
              stop_cnt <= stop_cnt + 1'b1;
            end else if (!empty) begin
              shreg   <= head;
              par_bit <= (^head) ^ PAR_ODD;
              state   <= ST_START;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: four parameter variants, frames decoded off the
// line by a mid-bit sampling receiver and compared against frames built from the word.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       dvld [4];
  logic [7:0] wdata;
  logic       ready [4];
  logic       ovf [4];
  logic       busy [4];
  logic       tx_a [4];
  logic [4:0] lvl0, lvl1, lvl3;
  logic [2:0] lvl2;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ov_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (ovf[1]) ov_cnt <= ov_cnt + 1;

  // 0: defaults; 1: defaults but 8 clk/bit; 2: 7 data, odd parity, 2 stop; 3: no parity.
  uart_tx_fifo u_def (
    .clk(clk), .rst(rst), .dvld(dvld[0]), .data(wdata), .ready(ready[0]),
    .overflow(ovf[0]), .level(lvl0), .busy(busy[0]), .uart_tx(tx_a[0]));

  uart_tx_fifo #(.CLK_FREQ(8_000_000), .BAUD_RATE(1_000_000)) u_fast (
    .clk(clk), .rst(rst), .dvld(dvld[1]), .data(wdata), .ready(ready[1]),
    .overflow(ovf[1]), .level(lvl1), .busy(busy[1]), .uart_tx(tx_a[1]));

  uart_tx_fifo #(.CLK_FREQ(8_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(7),
                 .PARITY_MODE(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_v7 (
    .clk(clk), .rst(rst), .dvld(dvld[2]), .data(wdata[6:0]), .ready(ready[2]),
    .overflow(ovf[2]), .level(lvl2), .busy(busy[2]), .uart_tx(tx_a[2]));

  uart_tx_fifo #(.CLK_FREQ(8_000_000), .BAUD_RATE(1_000_000), .PARITY_MODE(0)) u_np (
    .clk(clk), .rst(rst), .dvld(dvld[3]), .data(wdata), .ready(ready[3]),
    .overflow(ovf[3]), .level(lvl3), .busy(busy[3]), .uart_tx(tx_a[3]));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int lvl(input int i);
    case (i)
      0:       return int'(lvl0);
      1:       return int'(lvl1);
      2:       return int'(lvl2);
      default: return int'(lvl3);
    endcase
  endfunction

  function automatic int db_of(input int i); return (i == 2) ? 7 : 8; endfunction
  function automatic int pm_of(input int i); return (i == 2) ? 2 : (i == 3) ? 0 : 1; endfunction
  function automatic int sb_of(input int i); return (i == 2) ? 2 : 1; endfunction
  function automatic int flen(input int i);
    return 1 + db_of(i) + ((pm_of(i) != 0) ? 1 : 0) + sb_of(i);
  endfunction
  // Default NCO: INC = round(115200*65536/1e8) = 75, so 65536/75 clk per bit on average.
  function automatic real period(input int i); return (i == 0) ? 65536.0 / 75.0 : 8.0; endfunction

  // Expected line bits for one frame, index 0 = start bit.
  function automatic logic [15:0] model_frame(input int i, input logic [7:0] w);
    logic [15:0] f;
    int ones, pos;
    f = '1;
    f[0] = 1'b0;
    ones = 0;
    for (int j = 0; j < db_of(i); j++) begin
      f[1 + j] = w[j];
      ones += int'(w[j]);
    end
    pos = 1 + db_of(i);
    if (pm_of(i) == 1) f[pos] = (ones % 2) == 1;
    if (pm_of(i) == 2) f[pos] = (ones % 2) == 0;
    for (int j = flen(i); j < 16; j++) f[j] = 1'b0;
    return f;
  endfunction

  task automatic push(input int i, input logic [7:0] w);
    dvld[i] = 1'b1;
    wdata   = w;
    @(negedge clk);
    dvld[i] = 1'b0;
  endtask

  task automatic wait_tx(input int i, input logic v, input string tag, output int t);
    int lim;
    lim = cyc + int'(period(i) * 24.0) + 20;
    while (tx_a[i] !== v && cyc < lim) @(negedge clk);
    t = cyc;
    check({tag, "_edge"}, 64'(tx_a[i]), 64'(v));
  endtask

  task automatic rx_frame(input int i, input logic [7:0] w, input string tag, output int t0);
    logic [15:0] got;
    got = '0;
    wait_tx(i, 1'b0, tag, t0);
    for (int k = 0; k < flen(i); k++) begin
      while (cyc < t0 + int'((real'(k) + 0.5) * period(i))) @(negedge clk);
      got[k] = tx_a[i];
    end
    check(tag, 64'(got), 64'(model_frame(i, w)));
  endtask

  task automatic wait_idle(input int i, input string tag);
    int lim;
    lim = cyc + int'(period(i) * 30.0) + 50;
    while (busy[i] && cyc < lim) @(negedge clk);
    check(tag, 64'(busy[i]), 64'd0);
  endtask

  task automatic quiet(input int i, input int n, input string tag);
    int lows;
    lows = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx_a[i] !== 1'b1) lows++;
    end
    check(tag, 64'(lows), 64'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, tf, tr, c_drv, tprev, n;
    logic [7:0] words [8];
    logic [7:0] pat [4];

    rst = 1'b1;
    wdata = '0;
    for (int i = 0; i < 4; i++) dvld[i] = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_tx%0d", i),    64'(tx_a[i]),  64'd1);
      check($sformatf("rst_ready%0d", i), 64'(ready[i]), 64'd1);
      check($sformatf("rst_busy%0d", i),  64'(busy[i]),  64'd0);
      check($sformatf("rst_ovf%0d", i),   64'(ovf[i]),   64'd0);
      check($sformatf("rst_level%0d", i), 64'(lvl(i)),   64'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Default parameters: 0x12 frame, then bit period from the 0xFF start bit width.
    fork
      push(0, 8'h12);
      rx_frame(0, 8'h12, "def_12", t);
    join
    wait_idle(0, "def_12_idle");
    fork
      push(0, 8'hFF);
      rx_frame(0, 8'hFF, "def_FF", t);
      begin
        wait_tx(0, 1'b0, "def_fall", tf);
        wait_tx(0, 1'b1, "def_rise", tr);
        check("def_bit_period", 64'(tr - tf), 64'd874);  // first carry: ceil(65536/75)
      end
    join
    wait_idle(0, "def_FF_idle");

    // Single pushes on the fast instance, with write-to-start latency.
    pat[0] = 8'h00; pat[1] = 8'hAA; pat[2] = 8'h55; pat[3] = 8'h12;
    for (int p = 0; p < 4; p++) begin
      c_drv = cyc;
      fork
        push(1, pat[p]);
        rx_frame(1, pat[p], $sformatf("fast_%0h", pat[p]), t);
      join
      check("start_latency", 64'(t - (c_drv + 1)), 64'd2);
      wait_idle(1, "fast_idle");
    end

    // Burst of 17 (first is popped at once, so level peaks at 16), then a write on full.
    fork
      begin
        for (int w = 0; w < 17; w++) push(1, 8'(w));
        check("burst_level", 64'(lvl(1)), 64'd16);
        check("burst_ready", 64'(ready[1]), 64'd0);
        check("burst_no_ovf", 64'(ov_cnt), 64'd0);
        dvld[1] = 1'b1;
        wdata   = 8'hEE;
        @(negedge clk);
        dvld[1] = 1'b0;
        check("ovf_pulse", 64'(ovf[1]), 64'd1);
        check("ovf_level", 64'(lvl(1)), 64'd16);
        @(negedge clk);
        check("ovf_drop", 64'(ovf[1]), 64'd0);
      end
      begin
        tprev = 0;
        for (int k = 0; k < 17; k++) begin
          rx_frame(1, 8'(k), $sformatf("burst_%0d", k), t);
          if (k > 0) check($sformatf("contig_%0d", k), 64'(t - tprev), 64'(flen(1) * 8));
          tprev = t;
        end
        check("busy_last_stop", 64'(busy[1]), 64'd1);
      end
    join
    wait_idle(1, "burst_idle");
    check("ovf_once", 64'(ov_cnt), 64'd1);
    quiet(1, 200, "no_EE_frame");

    // Random bursts checked against the frame model.
    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(1, 8));
      for (int k = 0; k < n; k++) words[k] = 8'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      fork
        begin
          for (int k = 0; k < n; k++) push(1, words[k]);
          check("rnd_level", 64'(lvl(1)), 64'((n == 1) ? 1 : n - 1));
        end
        for (int k = 0; k < n; k++) rx_frame(1, words[k], $sformatf("rnd_%0d_%0d", r, k), t);
      join
      wait_idle(1, "rnd_idle");
    end

    // 7 data bits, odd parity, 2 stop bits.
    fork
      push(2, 8'h55);
      rx_frame(2, 8'h55, "v7_55", t);
    join
    wait_idle(2, "v7_idle");
    for (int k = 0; k < 3; k++) words[k] = 8'($urandom) & 8'h7F;
    fork
      for (int k = 0; k < 3; k++) push(2, words[k]);
      for (int k = 0; k < 3; k++) rx_frame(2, words[k], $sformatf("v7_rnd%0d", k), t);
    join
    wait_idle(2, "v7_rnd_idle");

    // No parity: 10-bit frames.
    fork
      push(3, 8'h80);
      rx_frame(3, 8'h80, "np_80", t);
    join
    wait_idle(3, "np_idle");
    for (int k = 0; k < 3; k++) words[k] = 8'($urandom);
    fork
      for (int k = 0; k < 3; k++) push(3, words[k]);
      for (int k = 0; k < 3; k++) rx_frame(3, words[k], $sformatf("np_rnd%0d", k), t);
    join
    wait_idle(3, "np_rnd_idle");

    // Reset in the middle of data bit 3 of 0xA5 (a 0 bit) with three words queued.
    fork
      begin
        push(1, 8'hA5); push(1, 8'h11); push(1, 8'h22); push(1, 8'h33);
      end
      wait_tx(1, 1'b0, "rst_mid_start", t);
    join
    while (cyc < t + 4 * 8 + 4) @(negedge clk);
    check("rst_mid_pre_tx", 64'(tx_a[1]), 64'd0);
    check("rst_mid_pre_level", 64'(lvl(1)), 64'd3);
    rst = 1'b1;
    #1;
    check("rst_mid_tx", 64'(tx_a[1]), 64'd1);
    check("rst_mid_level", 64'(lvl(1)), 64'd0);
    check("rst_mid_busy", 64'(busy[1]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    quiet(1, 300, "rst_mid_no_resume");
    check("rst_mid_busy_after", 64'(busy[1]), 64'd0);
    fork
      push(1, 8'h3C);
      rx_frame(1, 8'h3C, "post_rst_3C", t);
    join
    wait_idle(1, "post_rst_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
